// File: rtl/token_arb_pkg.sv
// Shared types for the GLB access arbiter: requester class and FSM state encodings.
package token_arb_pkg;

    typedef enum logic [1:0] {
        CLS_NONE,
        CLS_OPSUM,
        CLS_IFMAP,
        CLS_IPSUM
    } arb_class_e;

    typedef enum logic {
        ARB_IDLE,
        ARB_ISSUE
    } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: finds the first set request at or above ptr, wrapping N-1 -> 0.
module rr_picker #(
    parameter int unsigned N    = 32,
    parameter int unsigned PtrW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req,
    input  logic [PtrW-1:0] ptr,
    output logic            valid,
    output logic [PtrW-1:0] idx
);

    // Linear scan in rotated order; first hit wins.
    always_comb begin
        logic [PtrW-1:0] cand;
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = PtrW'((32'(ptr) + i) % N);
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/glb_access_arbiter.sv
// GLB port arbiter: one transaction at a time from three requester classes, registered
// request/address towards GLB, one-hot permit back to the winning channel on handshake.
module glb_access_arbiter
    import token_arb_pkg::*;
#(
    parameter int unsigned NUM_CH       = 32,
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned WEB_W        = 4,
    parameter int unsigned STARVE_LIMIT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] opsum_write_req_vec,
    input  logic [NUM_CH-1:0] ifmap_read_req_vec,
    input  logic [NUM_CH-1:0] ipsum_read_req_vec,
    input  logic [ADDR_W-1:0] opsum_write_addr_vec [NUM_CH],
    input  logic [WEB_W-1:0]  opsum_write_web_vec  [NUM_CH],
    input  logic [ADDR_W-1:0] ifmap_read_addr_vec  [NUM_CH],
    input  logic [ADDR_W-1:0] ipsum_read_addr_vec  [NUM_CH],
    input  logic              glb_ready,
    output logic              glb_read_req,
    output logic [ADDR_W-1:0] glb_read_addr,
    output logic              glb_write_req,
    output logic [ADDR_W-1:0] glb_write_addr,
    output logic [WEB_W-1:0]  glb_write_web,
    output logic [NUM_CH-1:0] permit_opsum,
    output logic [NUM_CH-1:0] permit_ifmap,
    output logic [NUM_CH-1:0] permit_ipsum
);

    localparam int unsigned PtrW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned CntW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    arb_state_e        state_q, state_d;
    arb_class_e        cls_q, win_cls;
    logic [PtrW-1:0]   idx_q, win_idx;
    logic [ADDR_W-1:0] addr_q, win_addr;
    logic [WEB_W-1:0]  web_q, win_web;
    logic [PtrW-1:0]   op_ptr_q, if_ptr_q, ip_ptr_q;
    logic [PtrW-1:0]   op_idx, if_idx, ip_idx;
    logic              op_any, if_any, ip_any;
    logic [CntW-1:0]   if_cnt_q, if_cnt_d, ip_cnt_q, ip_cnt_d;
    logic              if_starved, ip_starved;

    function automatic logic [PtrW-1:0] inc_ptr(input logic [PtrW-1:0] p);
        return (32'(p) == NUM_CH - 1) ? '0 : p + PtrW'(1);
    endfunction

    rr_picker #(.N(NUM_CH), .PtrW(PtrW)) u_pick_opsum (
        .req   (opsum_write_req_vec),
        .ptr   (op_ptr_q),
        .valid (op_any),
        .idx   (op_idx)
    );

    rr_picker #(.N(NUM_CH), .PtrW(PtrW)) u_pick_ifmap (
        .req   (ifmap_read_req_vec),
        .ptr   (if_ptr_q),
        .valid (if_any),
        .idx   (if_idx)
    );

    rr_picker #(.N(NUM_CH), .PtrW(PtrW)) u_pick_ipsum (
        .req   (ipsum_read_req_vec),
        .ptr   (ip_ptr_q),
        .valid (ip_any),
        .idx   (ip_idx)
    );

    // Class selection: starved reads (ifmap first) beat the fixed opsum > ifmap > ipsum order.
    always_comb begin
        if_starved = (STARVE_LIMIT != 0) && if_any && (if_cnt_q == CntW'(STARVE_LIMIT));
        ip_starved = (STARVE_LIMIT != 0) && ip_any && (ip_cnt_q == CntW'(STARVE_LIMIT));
        win_cls    = CLS_NONE;
        win_idx    = '0;
        win_addr   = '0;
        win_web    = '0;
        if (state_q == ARB_IDLE) begin
            if (if_starved)      win_cls = CLS_IFMAP;
            else if (ip_starved) win_cls = CLS_IPSUM;
            else if (op_any)     win_cls = CLS_OPSUM;
            else if (if_any)     win_cls = CLS_IFMAP;
            else if (ip_any)     win_cls = CLS_IPSUM;
        end
        unique case (win_cls)
            CLS_OPSUM: begin
                win_idx  = op_idx;
                win_addr = opsum_write_addr_vec[op_idx];
                win_web  = opsum_write_web_vec[op_idx];
            end
            CLS_IFMAP: begin
                win_idx  = if_idx;
                win_addr = ifmap_read_addr_vec[if_idx];
            end
            CLS_IPSUM: begin
                win_idx  = ip_idx;
                win_addr = ipsum_read_addr_vec[ip_idx];
            end
            default: ;
        endcase
    end

    // Aging: count lost arbitrations while pending, clear on win or empty vector, saturate.
    always_comb begin
        if_cnt_d = if_cnt_q;
        ip_cnt_d = ip_cnt_q;
        if (state_q == ARB_IDLE) begin
            if (win_cls == CLS_IFMAP || !if_any)         if_cnt_d = '0;
            else if (if_cnt_q < CntW'(STARVE_LIMIT))     if_cnt_d = if_cnt_q + CntW'(1);
            if (win_cls == CLS_IPSUM || !ip_any)         ip_cnt_d = '0;
            else if (ip_cnt_q < CntW'(STARVE_LIMIT))     ip_cnt_d = ip_cnt_q + CntW'(1);
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ARB_IDLE;
        else     state_q <= state_d;
    end

    // FSM next state: leave IDLE on any request, leave ISSUE on handshake.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARB_IDLE:  if (win_cls != CLS_NONE) state_d = ARB_ISSUE;
            ARB_ISSUE: if (glb_ready)           state_d = ARB_IDLE;
            default:                            state_d = ARB_IDLE;
        endcase
    end

    // Transaction latch, RR pointers and aging counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            cls_q    <= CLS_NONE;
            idx_q    <= '0;
            addr_q   <= '0;
            web_q    <= '0;
            op_ptr_q <= '0;
            if_ptr_q <= '0;
            ip_ptr_q <= '0;
            if_cnt_q <= '0;
            ip_cnt_q <= '0;
        end else begin
            if_cnt_q <= if_cnt_d;
            ip_cnt_q <= ip_cnt_d;
            if (win_cls != CLS_NONE) begin
                cls_q  <= win_cls;
                idx_q  <= win_idx;
                addr_q <= win_addr;
                web_q  <= win_web;
                unique case (win_cls)
                    CLS_OPSUM: op_ptr_q <= inc_ptr(win_idx);
                    CLS_IFMAP: if_ptr_q <= inc_ptr(win_idx);
                    CLS_IPSUM: ip_ptr_q <= inc_ptr(win_idx);
                    default: ;
                endcase
            end
        end
    end

    // Outputs: driven only from latched state; permit also needs glb_ready.
    always_comb begin
        glb_read_req   = 1'b0;
        glb_read_addr  = '0;
        glb_write_req  = 1'b0;
        glb_write_addr = '0;
        glb_write_web  = '0;
        permit_opsum   = '0;
        permit_ifmap   = '0;
        permit_ipsum   = '0;
        if (state_q == ARB_ISSUE) begin
            unique case (cls_q)
                CLS_OPSUM: begin
                    glb_write_req  = 1'b1;
                    glb_write_addr = addr_q;
                    glb_write_web  = web_q;
                    permit_opsum[idx_q] = glb_ready;
                end
                CLS_IFMAP: begin
                    glb_read_req  = 1'b1;
                    glb_read_addr = addr_q;
                    permit_ifmap[idx_q] = glb_ready;
                end
                CLS_IPSUM: begin
                    glb_read_req  = 1'b1;
                    glb_read_addr = addr_q;
                    permit_ipsum[idx_q] = glb_ready;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_glb_access_arbiter.sv
// Directed self-checking bench for glb_access_arbiter (aging on and off instances).
module tb_glb_access_arbiter;

    localparam int NCH = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] op_req, if_req, ip_req;
    logic [31:0] op_addr [NCH];
    logic [3:0]  op_web  [NCH];
    logic [31:0] if_addr [NCH];
    logic [31:0] ip_addr [NCH];
    logic        ready;

    logic        rd_req, wr_req;
    logic [31:0] rd_addr, wr_addr;
    logic [3:0]  wr_web;
    logic [31:0] p_op, p_if, p_ip;

    logic        d0_rd_req, d0_wr_req;
    logic [31:0] d0_rd_addr, d0_wr_addr;
    logic [3:0]  d0_wr_web;
    logic [31:0] d0_p_op, d0_p_if, d0_p_ip;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    glb_access_arbiter #(.NUM_CH(NCH), .ADDR_W(32), .WEB_W(4), .STARVE_LIMIT(15)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .opsum_write_req_vec  (op_req),
        .ifmap_read_req_vec   (if_req),
        .ipsum_read_req_vec   (ip_req),
        .opsum_write_addr_vec (op_addr),
        .opsum_write_web_vec  (op_web),
        .ifmap_read_addr_vec  (if_addr),
        .ipsum_read_addr_vec  (ip_addr),
        .glb_ready            (ready),
        .glb_read_req         (rd_req),
        .glb_read_addr        (rd_addr),
        .glb_write_req        (wr_req),
        .glb_write_addr       (wr_addr),
        .glb_write_web        (wr_web),
        .permit_opsum         (p_op),
        .permit_ifmap         (p_if),
        .permit_ipsum         (p_ip)
    );

    glb_access_arbiter #(.NUM_CH(NCH), .ADDR_W(32), .WEB_W(4), .STARVE_LIMIT(0)) dut0 (
        .clk                  (clk),
        .rst                  (rst),
        .opsum_write_req_vec  (op_req),
        .ifmap_read_req_vec   (if_req),
        .ipsum_read_req_vec   (ip_req),
        .opsum_write_addr_vec (op_addr),
        .opsum_write_web_vec  (op_web),
        .ifmap_read_addr_vec  (if_addr),
        .ipsum_read_addr_vec  (ip_addr),
        .glb_ready            (ready),
        .glb_read_req         (d0_rd_req),
        .glb_read_addr        (d0_rd_addr),
        .glb_write_req        (d0_wr_req),
        .glb_write_addr       (d0_wr_addr),
        .glb_write_web        (d0_wr_web),
        .permit_opsum         (d0_p_op),
        .permit_ifmap         (d0_p_if),
        .permit_ipsum         (d0_p_ip)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 2 time units after the edge.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Expected address/web values are the bench's own fixed channel encoding.
    function automatic logic [31:0] exp_addr(input int cls, input int idx);
        case (cls)
            1:       return 32'hA000_0000 | 32'(idx);
            2:       return 32'hB000_0000 | 32'(idx);
            default: return 32'hC000_0000 | 32'(idx);
        endcase
    endfunction

    // From IDLE with ready=1: expect class cls (1 op, 2 if, 3 ip) channel idx, then IDLE.
    task automatic grant(input string tag, input int cls, input int idx, input bit drop);
        logic [31:0] oh;
        oh = 32'd1 << idx;
        cyc();
        check_eq($sformatf("%s.wr_req", tag), 64'(wr_req), 64'(cls == 1));
        check_eq($sformatf("%s.rd_req", tag), 64'(rd_req), 64'(cls != 1));
        if (cls == 1) begin
            check_eq($sformatf("%s.wr_addr", tag), 64'(wr_addr), 64'(exp_addr(cls, idx)));
            check_eq($sformatf("%s.wr_web", tag), 64'(wr_web), 64'(idx % 16));
        end else begin
            check_eq($sformatf("%s.rd_addr", tag), 64'(rd_addr), 64'(exp_addr(cls, idx)));
        end
        check_eq($sformatf("%s.permit", tag), {p_op, p_if, p_ip},
                 (cls == 1) ? {oh, 32'd0, 32'd0} :
                 (cls == 2) ? {32'd0, oh, 32'd0} : {32'd0, 32'd0, oh});
        if (drop) begin
            case (cls)
                1:       op_req[idx] = 1'b0;
                2:       if_req[idx] = 1'b0;
                default: ip_req[idx] = 1'b0;
            endcase
        end
        cyc();
        check_eq($sformatf("%s.idle", tag), 64'({rd_req, wr_req, p_op, p_if, p_ip}), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NCH; i++) begin
            op_addr[i] = 32'hA000_0000 | 32'(i);
            op_web[i]  = 4'(i);
            if_addr[i] = 32'hB000_0000 | 32'(i);
            ip_addr[i] = 32'hC000_0000 | 32'(i);
        end
        rst = 1'b1; op_req = '0; if_req = '0; ip_req = '0; ready = 1'b0;
        repeat (3) cyc();
        check_eq("reset.outs", 64'({rd_req, wr_req, wr_web}), 64'd0);
        check_eq("reset.addr", {rd_addr, wr_addr}, 64'd0);
        check_eq("reset.permit", 64'({p_op, p_if, p_ip}), 64'd0);

        // Reset in the middle of a stalled write transaction.
        rst = 1'b0;
        op_req = 32'd1 << 5;
        cyc();
        check_eq("t1.wr_req", 64'(wr_req), 64'd1);
        check_eq("t1.wr_addr", 64'(wr_addr), 64'hA000_0005);
        rst = 1'b1; op_req = '0;
        cyc();
        ready = 1'b1;
        #1;
        check_eq("t1.rst_outs", 64'({rd_req, wr_req, wr_web, wr_addr}), 64'd0);
        check_eq("t1.rst_permit", 64'({p_op, p_if, p_ip}), 64'd0);
        rst = 1'b0;
        // Opsum pointer must be back at 0: channel 0 beats channel 6.
        op_req = 32'h0000_0041;
        grant("t1.ptr0", 1, 0, 1'b1);
        grant("t1.ptr6", 1, 6, 1'b1);

        // Round-robin within ifmap.
        if_req = 32'h0000_0005;
        grant("t2.ch0", 2, 0, 1'b1);
        grant("t2.ch2", 2, 2, 1'b1);
        if_req = 32'h0000_000A;
        grant("t2.ptr3", 2, 3, 1'b1);
        grant("t2.ch1", 2, 1, 1'b1);

        // Opsum beats ifmap, then ifmap follows.
        op_req = 32'd1 << 7;
        if_req = 32'd1 << 3;
        grant("t3.op7", 1, 7, 1'b1);
        grant("t3.if3", 2, 3, 1'b1);

        // Stall five cycles in ISSUE; latched address must ignore input changes.
        ready = 1'b0;
        ip_req = 32'd1 << 9;
        cyc();
        check_eq("t4.rd_req0", 64'(rd_req), 64'd1);
        check_eq("t4.rd_addr0", 64'(rd_addr), 64'hC000_0009);
        check_eq("t4.permit0", 64'({p_op, p_if, p_ip}), 64'd0);
        ip_addr[9] = 32'hDEAD_BEEF;
        for (int i = 1; i < 5; i++) begin
            cyc();
            check_eq($sformatf("t4.hold%0d", i), {16'd0, rd_req, wr_req, 14'd0, rd_addr},
                     {16'd0, 1'b1, 1'b0, 14'd0, 32'hC000_0009});
            check_eq($sformatf("t4.nopermit%0d", i), 64'({p_op, p_if, p_ip}), 64'd0);
        end
        ready = 1'b1;
        #1;
        check_eq("t4.permit", 64'({p_op, p_if, p_ip}), 64'(32'd1 << 9));
        ip_req = '0;
        ip_addr[9] = 32'hC000_0009;
        cyc();
        check_eq("t4.idle", 64'({rd_req, wr_req, p_ip}), 64'd0);

        // Ipsum pointer wrap: 30 -> ptr 31, then 31, 0, and ptr lands on 1.
        ip_req = 32'd1 << 30;
        grant("t6.ch30", 3, 30, 1'b1);
        ip_req = 32'hFFFF_FFFF;
        grant("t6.ch31", 3, 31, 1'b1);
        grant("t6.ch0", 3, 0, 1'b1);
        ip_req[0] = 1'b1;
        grant("t6.ptr1", 3, 1, 1'b1);
        ip_req = '0;

        // Aging: opsum requests constantly; ifmap ch1 wins arbitration 16 only with aging on.
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        op_req = 32'hFFFF_FFFF;
        if_req = 32'd1 << 1;
        for (int k = 1; k <= 18; k++) begin
            cyc();
            if (k == 16) begin
                check_eq($sformatf("t5.arb%0d", k), 64'({rd_req, wr_req, p_if}), {31'd0, 2'b10, 32'd2});
                if_req = '0;
            end else if (k < 16) begin
                check_eq($sformatf("t5.arb%0d", k), 64'({rd_req, wr_req, p_op}),
                         {30'd0, 2'b01, 32'd1 << (k - 1)});
            end
            check_eq($sformatf("t5.noage%0d", k), {d0_p_if, d0_p_op}, {32'd0, 32'd1 << (k - 1)});
            cyc();
        end
        op_req = '0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
